// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter for the register bank; one registered write per cycle, register 0 never enabled.
// Optional build macro REGFILE_ARB_FIXED_PRIO_EN switches to fixed lowest-index-first priority.
module regfile_wr_arbiter #(
   parameter int SIZE    = 8,
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NUM_REQ-1:0]          req_i,
   input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
   input  logic [NUM_REQ*SIZE-1:0]     data_i,
   output logic [NUM_REQ-1:0]          gnt_o,
   output logic [(1<<ADDR_W)-1:0]      wr_en_o,
   output logic [SIZE-1:0]             din_o
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int NREG  = 1 << ADDR_W;

   logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
   logic [NUM_REQ-1:0][SIZE-1:0]   data_a;

   for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
      assign addr_a[r] = addr_i[r*ADDR_W +: ADDR_W];
      assign data_a[r] = data_i[r*SIZE +: SIZE];
   end

   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NREG-1:0]    wr_en_q, wr_en_d;
   logic [SIZE-1:0]    din_q, din_d;
   logic [PTR_W-1:0]   start;
   logic [NUM_REQ-1:0] elig;
   logic               win;
   logic [PTR_W-1:0]   win_idx;
   int                 idx;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
   assign start = '0;
`else
   logic [PTR_W-1:0] ptr_q, ptr_d;
   assign start = ptr_q;
`endif

   // This cycle's winner is masked so a held request cannot be granted twice in a row.
   always_comb begin
      elig    = req_i & ~gnt_q;
      win     = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(start) + k) % NUM_REQ;
         if (!win && elig[idx]) begin
            win     = 1'b1;
            win_idx = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      gnt_d   = '0;
      wr_en_d = '0;
      din_d   = din_q;
      if (win) begin
         gnt_d[win_idx] = 1'b1;
         din_d          = data_a[win_idx];
         // Address 0 completes the handshake but never writes the zero register.
         if (addr_a[win_idx] != '0)
            wr_en_d[addr_a[win_idx]] = 1'b1;
      end
   end

`ifndef REGFILE_ARB_FIXED_PRIO_EN
   always_comb begin
      ptr_d = ptr_q;
      if (win)
         ptr_d = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : PTR_W'(win_idx + 1'b1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gnt_q   <= '0;
         wr_en_q <= '0;
         din_q   <= '0;
      end else begin
         gnt_q   <= gnt_d;
         wr_en_q <= wr_en_d;
         din_q   <= din_d;
      end
   end

   assign gnt_o   = gnt_q;
   assign wr_en_o = wr_en_q;
   assign din_o   = din_q;

endmodule
